encoder_bank: RTL and testbench

Parametrised bank of quadrature rotary-encoder front-ends for panel controls. It replaces single-channel, free-running decoders with up to NUM_ENC channels. Each channel has input synchronisation, a glitch filter, legal-transition decoding, detent scaling, saturate/wrap selection, software preload and an illegal-transition flag. It sits between the board encoder pins and the LED/effect control logic (e.g. the ws2812c colour/brightness path), which consumes `count` and the one-cycle event strobes.

---
 rtl/encoder_bank_pkg.sv | 42 ++++
 rtl/encoder_channel.sv | 153 +++++++++++++++
 rtl/encoder_bank.sv | 70 +++++++
 tb/tb_encoder_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_bank_pkg.sv
// encoder_bank shared types: quadrature phase codes,
// step direction codes and filter counter sizing.
package encoder_bank_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Run counter only needs to reach len-1.
  function automatic int filt_cnt_w(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic dir_e decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    dir_e d;
    d = DIR_NONE;
    case ({prev, cur})
      {PH_00, PH_10},
      {PH_10, PH_11},
      {PH_11, PH_01},
      {PH_01, PH_00}: d = DIR_UP;
      {PH_10, PH_00},
      {PH_11, PH_10},
      {PH_01, PH_11},
      {PH_00, PH_01}: d = DIR_DOWN;
      default:        d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/encoder_channel.sv
// One encoder channel: sync, glitch filter, decode,
// detent scaling, count, sticky err, switch debounce.
// Ports: clk, reset (async, active-low), a/b/sw raw
// pins, wrap mode, tick (debounce sample strobe),
// load/load_value preload; count, changed, press, err.
// Switch logic is built only with ENCODER_BANK_SWITCH_EN.
module encoder_channel
  import encoder_bank_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int FILTER_LEN = 4,
  parameter int STEP_SHIFT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a,
  input  logic            b,
  input  logic            sw,
  input  logic            wrap,
  input  logic            tick,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] count,
  output logic            changed,
  output logic            press,
  output logic            err
);

  localparam int CW = filt_cnt_w(FILTER_LEN);
  localparam int AW = (STEP_SHIFT > 0) ? STEP_SHIFT : 1;
  localparam logic [AW-1:0] ACC_MAX =
    AW'((1 << STEP_SHIFT) - 1);
  localparam logic [CW-1:0] RUN_END = CW'(FILTER_LEN - 1);
  localparam logic [BITS-1:0] CNT_MAX = '1;

  logic [1:0]      s1, s2, filt, prev;
  logic [CW-1:0]   run [2];
  logic [AW-1:0]   acc, acc_nxt;
  logic [BITS-1:0] cnt_nxt;
  logic            step_up, step_dn, jump;
  dir_e            dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
  end

  // Level accepted after FILTER_LEN cycles of disagreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt   <= PH_00;
      run[0] <= '0;
      run[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s2[k] == filt[k]) begin
          run[k] <= '0;
        end else if (run[k] == RUN_END) begin
          filt[k] <= s2[k];
          run[k]  <= '0;
        end else begin
          run[k] <= run[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    dir     = decode(prev, filt);
    jump    = (prev ^ filt) == 2'b11;
    acc_nxt = acc;
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case (1'b1)
      dir == DIR_UP: begin
        if (acc == ACC_MAX) begin
          step_up = 1'b1;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc + AW'(1);
        end
      end
      dir == DIR_DOWN: begin
        if (acc == '0) begin
          step_dn = 1'b1;
          acc_nxt = ACC_MAX;
        end else begin
          acc_nxt = acc - AW'(1);
        end
      end
      default: ;
    endcase
    cnt_nxt = count;
    if (step_up && (wrap || count != CNT_MAX))
      cnt_nxt = count + BITS'(1);
    if (step_dn && (wrap || count != '0))
      cnt_nxt = count - BITS'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev    <= PH_00;
      acc     <= '0;
      count   <= '0;
      changed <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev    <= filt;
      changed <= 1'b0;
      if (load) begin
        count <= load_value;
        acc   <= '0;
        err   <= 1'b0;
      end else begin
        count   <= cnt_nxt;
        acc     <= acc_nxt;
        changed <= cnt_nxt != count;
        if (jump) err <= 1'b1;
      end
    end
  end

`ifdef ENCODER_BANK_SWITCH_EN
  logic [1:0] sws;
  logic [2:0] sh;

  // Newest sample enters at bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sws   <= 2'b00;
      sh    <= 3'b000;
      press <= 1'b0;
    end else begin
      sws   <= {sws[0], sw};
      press <= 1'b0;
      if (tick) begin
        sh    <= {sh[1:0], sws[1]};
        press <= {sh[1:0], sws[1]} == 3'b011;
      end
    end
  end
`else
  logic unused_sw;
  assign unused_sw = sw ^ tick;
  assign press     = 1'b0;
`endif

endmodule

// File: rtl/encoder_bank.sv
// Bank of NUM_ENC quadrature encoder front-ends with
// shared debounce prescaler and preload decode.
// Ports: clk, reset (async, active-low), enc_a/enc_b/
// enc_sw raw pins, wrap per channel, load_en/load_sel/
// load_value preload; count (BITS per channel), changed,
// press, err. ENCODER_BANK_SWITCH_EN builds switch logic.
module encoder_bank
  import encoder_bank_pkg::*;
#(
  parameter int NUM_ENC       = 2,
  parameter int BITS          = 8,
  parameter int FILTER_LEN    = 4,
  parameter int STEP_SHIFT    = 2,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_ENC-1:0]      enc_a,
  input  logic [NUM_ENC-1:0]      enc_b,
  input  logic [NUM_ENC-1:0]      enc_sw,
  input  logic [NUM_ENC-1:0]      wrap,
  input  logic                    load_en,
  input  logic [2:0]              load_sel,
  input  logic [BITS-1:0]         load_value,
  output logic [NUM_ENC*BITS-1:0] count,
  output logic [NUM_ENC-1:0]      changed,
  output logic [NUM_ENC-1:0]      press,
  output logic [NUM_ENC-1:0]      err
);

  logic tick;

`ifdef ENCODER_BANK_SWITCH_EN
  logic [DEBOUNCE_BITS-1:0] pre;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre <= '0;
    else        pre <= pre + DEBOUNCE_BITS'(1);
  end

  assign tick = &pre;
`else
  localparam int unused_debounce = DEBOUNCE_BITS;
  assign tick = 1'b0;
`endif

  // Channel index match doubles as the range check.
  for (genvar i = 0; i < NUM_ENC; i++) begin : g_ch
    encoder_channel #(
      .BITS       (BITS),
      .FILTER_LEN (FILTER_LEN),
      .STEP_SHIFT (STEP_SHIFT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .a          (enc_a[i]),
      .b          (enc_b[i]),
      .sw         (enc_sw[i]),
      .wrap       (wrap[i]),
      .tick       (tick),
      .load       (load_en && (load_sel == 3'(i))),
      .load_value (load_value),
      .count      (count[i*BITS +: BITS]),
      .changed    (changed[i]),
      .press      (press[i]),
      .err        (err[i])
    );
  end

endmodule

// File: tb/tb_encoder_bank.sv
// Scoreboard bench for encoder_bank: directed encoder
// sequences, saturation, filter timing, preload, switch.
module tb_encoder_bank;
  import encoder_bank_pkg::*;

  localparam int N = 2;
  localparam int B = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   enc_a = '0;
  logic [N-1:0]   enc_b = '0;
  logic [N-1:0]   enc_sw = '0;
  logic [N-1:0]   wrap = '1;
  logic           load_en = 1'b0;
  logic [2:0]     load_sel = '0;
  logic [B-1:0]   load_value = '0;
  logic [N*B-1:0] count;
  logic [N-1:0]   changed;
  logic [N-1:0]   press;
  logic [N-1:0]   err;

  encoder_bank #(
    .NUM_ENC       (N),
    .BITS          (B),
    .FILTER_LEN    (4),
    .STEP_SHIFT    (2),
    .DEBOUNCE_BITS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_sw     (enc_sw),
    .wrap       (wrap),
    .load_en    (load_en),
    .load_sel   (load_sel),
    .load_value (load_value),
    .count      (count),
    .changed    (changed),
    .press      (press),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int ch;
    int val;
    int cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int cnt(input int ch);
    return int'(count[ch*B +: B]);
  endfunction

  task automatic push(input int kind, input int ch,
                      input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    e.val  = val;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input int ch,
                         input int val);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event kind=%0d ch=%0d val=%0d cyc=%0d",
               kind, ch, val, cyc);
    end else begin
      e = q.pop_front();
      check("sb kind", kind, e.kind);
      check("sb channel", ch, e.ch);
      check("sb value", val, e.val);
      if (e.cyc >= 0) check("sb cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (changed[i]) observe(0, i, cnt(i));
        if (press[i])   observe(1, i, 0);
      end
    end
  end

  task automatic drive(input int ch, input logic [1:0] ph);
    @(negedge clk);
    enc_a[ch] = ph[1];
    enc_b[ch] = ph[0];
  endtask

  task automatic move(input int ch, input logic [1:0] ph);
    drive(ch, ph);
    repeat (8) @(negedge clk);
  endtask

  task automatic load(input int ch, input int val);
    @(negedge clk);
    load_en    = 1'b1;
    load_sel   = 3'(ch);
    load_value = B'(val);
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  int c0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset count0", cnt(0), 0);
    check("reset count1", cnt(1), 0);
    check("reset changed", int'(changed), 0);
    check("reset press", int'(press), 0);
    check("reset err", int'(err), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 3 CW cycles: one step per detent
    for (int k = 1; k <= 3; k++) begin
      move(0, PH_10);
      move(0, PH_11);
      move(0, PH_01);
      push(0, 0, k, -1);
      move(0, PH_00);
    end
    check("cw 3 detents", cnt(0), 3);

    // 1 CCW cycle: first down edge borrows a step
    push(0, 0, 2, -1);
    move(0, PH_01);
    move(0, PH_11);
    move(0, PH_10);
    move(0, PH_00);
    check("ccw 1 detent", cnt(0), 2);

    // saturate at top, then wrap to 0
    wrap[0] = 1'b0;
    load(0, 255);
    check("preload 255", cnt(0), 255);
    move(0, PH_10);
    move(0, PH_11);
    move(0, PH_01);
    move(0, PH_00);
    check("saturate hold", cnt(0), 255);
    wrap[0] = 1'b1;
    move(0, PH_10);
    move(0, PH_11);
    move(0, PH_01);
    push(0, 0, 0, -1);
    move(0, PH_00);
    check("wrap to 0", cnt(0), 0);

    // 3-clock glitch rejected
    load(0, 8'h10);
    @(negedge clk);
    enc_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    enc_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch count", cnt(0), 8'h10);
    check("glitch err", int'(err[0]), 0);

    // stable edge: update 7 edges after first sample
    drive(0, PH_01);
    c0 = cyc;
    push(0, 0, 8'h0f, c0 + 7);
    repeat (8) @(negedge clk);
    push(0, 0, 8'h10, -1);
    move(0, PH_00);
    check("latency back", cnt(0), 8'h10);

    // phase jump sets err, preload clears it
    move(1, PH_11);
    check("jump err1", int'(err[1]), 1);
    check("jump count1", cnt(1), 0);
    check("jump err0", int'(err[0]), 0);
    load(1, 8'h80);
    check("preload ch1", cnt(1), 8'h80);
    check("preload clr err", int'(err[1]), 0);
    move(1, PH_01);
    move(1, PH_00);
    check("ch1 sub-step", cnt(1), 8'h80);

    // load on the step-completion edge wins
    move(0, PH_10);
    move(0, PH_11);
    move(0, PH_01);
    drive(0, PH_00);
    repeat (6) @(negedge clk);
    load_en    = 1'b1;
    load_sel   = 3'd0;
    load_value = 8'h55;
    @(negedge clk);
    load_en = 1'b0;
    check("load vs step", cnt(0), 8'h55);
    repeat (4) @(negedge clk);
    check("load vs step hold", cnt(0), 8'h55);

    // out-of-range channel ignored
    load(7, 8'haa);
    check("sel7 ch0", cnt(0), 8'h55);
    check("sel7 ch1", cnt(1), 8'h80);

    // bouncing switch: one press
`ifdef ENCODER_BANK_SWITCH_EN
    push(1, 0, 0, -1);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enc_sw[0] = (i % 2) == 0;
    end
    repeat (100) @(negedge clk);
    enc_sw[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("sb drained", q.size(), 0);

    // async reset mid-sequence
    move(1, PH_11);
    check("pre-reset err1", int'(err[1]), 1);
    drive(0, PH_10);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset count0", cnt(0), 0);
    check("areset count1", cnt(1), 0);
    check("areset err", int'(err), 0);
    check("areset changed", int'(changed), 0);
    check("areset press", int'(press), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
